// File: rtl/ascon_perm_engine.sv
`default_nettype none
// ============================================================================
// ascon_perm_engine : iterative ASCON permutation, UNROLL rounds per clock
// Revision 1.0
// ============================================================================
module ascon_perm_engine #(
    parameter int UNROLL  = 1,
    parameter int SLICE_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [319:0] state_o,
    output logic         busy_o
);

    localparam int W = SLICE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    logic [319:0] st_q;
    logic [319:0] st_d;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [3:0]   nr_q;
    logic [3:0]   nr_d;
    logic         ready_q;
    logic         valid_q;
    logic         busy_q;

    logic [319:0] w_r1;
    logic [319:0] w_r2;
    logic [3:0]   w_ridx;
    logic [3:0]   w_left;
    logic         w_two;
    logic         w_last;

    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input int n);
        return (x >> n) | (x << (W - n));
    endfunction

    function automatic logic [319:0] round_f(input logic [319:0] s, input logic [3:0] r);
        logic [W-1:0] x0, x1, x2, x3, x4;
        logic [W-1:0] t0, t1, t2, t3, t4;
        x0 = s[4*W +: W];
        x1 = s[3*W +: W];
        x2 = s[2*W +: W];
        x3 = s[1*W +: W];
        x4 = s[0*W +: W];
        // Round constant: high nibble (15-r) is the 4-bit complement of r
        x2 = x2 ^ {{(W-8){1'b0}}, ~r, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Second stage is bypassed when only one round is left
    always_comb begin
        w_ridx = 4'd12 - nr_q + cnt_q;
        w_left = nr_q - cnt_q;
        w_r1   = round_f(st_q, w_ridx);
        w_r2   = round_f(w_r1, w_ridx + 4'd1);
        w_two  = (UNROLL == 2) && (w_left >= 4'd2);
        st_d   = w_two ? w_r2 : w_r1;
        cnt_d  = cnt_q + (w_two ? 4'd2 : 4'd1);
        w_last = (cnt_d == nr_q);
        nr_d   = ((rounds_i == 4'd0) || (rounds_i > 4'd12)) ? 4'd12 : rounds_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            st_q    <= '0;
            nr_q    <= 4'd12;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        st_q    <= state_i;
                        nr_q    <= nr_d;
                        cnt_q   <= 4'd0;
                        fsm_q   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    st_q  <= st_d;
                    cnt_q <= cnt_d;
                    if (w_last) begin
                        fsm_q   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_q   <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign state_o     = st_q;

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_engine.sv
`default_nettype none
// ============================================================================
// tb_ascon_perm_engine : UNROLL=1 and UNROLL=2 engines vs table-driven model
// Revision 1.0
// ============================================================================
module tb_ascon_perm_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [3:0]   rounds;
    logic [319:0] st_in;
    logic         rdy1, vld1, bsy1, rdy2, vld2, bsy2;
    logic [319:0] so1, so2;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    ascon_perm_engine #(.UNROLL(1), .SLICE_W(64)) dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .rounds_i(rounds), .state_i(st_in), .out_valid_o(vld1),
        .out_ready_i(out_ready), .state_o(so1), .busy_o(bsy1)
    );

    ascon_perm_engine #(.UNROLL(2), .SLICE_W(64)) dut2 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy2),
        .rounds_i(rounds), .state_i(st_in), .out_valid_o(vld2),
        .out_ready_i(out_ready), .state_o(so2), .busy_o(bsy2)
    );

    // 5-bit S-box lookup, x0 is the MSB of the column value
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic int eff_nr(input int r);
        return ((r == 0) || (r > 12)) ? 12 : r;
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[v];
                for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
            end
            for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], RA[i]) ^ rotr(y[i], RB[i]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request to both engines (out_ready high), check latency and result
    task automatic do_req(input logic [3:0] rin, input logic [319:0] s, input string tag,
                          output logic [319:0] r1, output int l1, output int l2);
        int           nr;
        logic [319:0] exp;
        logic [319:0] r2;
        nr  = eff_nr(int'(rin));
        exp = ref_perm(s, nr);
        rounds   = rin;
        st_in    = s;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        st_in    = rand320();
        l1 = -1; l2 = -1; r1 = '0; r2 = '0;
        for (int k = 1; k <= 40 && (l1 < 0 || l2 < 0); k++) begin
            @(negedge clk);
            if (vld1 && l1 < 0) begin l1 = k; r1 = so1; end
            if (vld2 && l2 < 0) begin l2 = k; r2 = so2; end
        end
        chk_int({tag, " lat_u1"}, l1, nr);
        chk_int({tag, " lat_u2"}, l2, (nr + 1) / 2);
        chk({tag, " res_u1"}, r1, exp);
        chk({tag, " res_u2"}, r2, exp);
        @(negedge clk);
    endtask

    initial begin
        logic [319:0] ra, rb, sa, exp;
        int           la, lb, l2a, l2b, l1s, l2s;
        logic         bad, saw;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rounds = 4'd0; st_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst rdy_u1", 320'(rdy1), 320'd1);
        chk("rst vld_u1", 320'(vld1), 320'd0);
        chk("rst bsy_u1", 320'(bsy1), 320'd0);
        chk("rst st_u1", so1, '0);
        chk("rst rdy_u2", 320'(rdy2), 320'd1);
        chk("rst vld_u2", 320'(vld2), 320'd0);
        chk("rst bsy_u2", 320'(bsy2), 320'd0);
        chk("rst st_u2", so2, '0);

        // Single round on the all-zero state
        do_req(4'd1, '0, "nr1", ra, la, l2a);
        chk("nr1 x2", 320'(ra[191:128]), 320'(64'h53FF_FFFF_FFFF_FF90));
        chk("nr1 x4", 320'(ra[63:0]), 320'd0);

        // Full permutation with consumer stalled for 5 cycles after DONE
        out_ready = 1'b0; rounds = 4'd12; st_in = '0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        l1s = -1; l2s = -1; bad = 1'b0; ra = '0; rb = '0;
        for (int k = 1; k <= 40 && l1s < 0; k++) begin
            @(negedge clk);
            if (rdy1 || rdy2) bad = 1'b1;
            if (vld1 && l1s < 0) begin l1s = k; ra = so1; end
            if (vld2 && l2s < 0) begin l2s = k; rb = so2; end
        end
        chk_int("stall lat_u1", l1s, 12);
        chk_int("stall lat_u2", l2s, 6);
        exp = ref_perm('0, 12);
        chk("stall res_u1", ra, exp);
        chk("stall res_u2", rb, exp);
        repeat (5) begin
            @(negedge clk);
            if (rdy1 || rdy2 || !vld1 || !vld2 || so1 !== ra || so2 !== rb) bad = 1'b1;
        end
        chk("stall hold", 320'(bad), 320'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall release", {318'd0, vld1, rdy1}, 320'd1);

        // rounds_i = 0 behaves as 12
        sa = rand320();
        do_req(4'd0, sa, "nr0", ra, la, l2a);
        do_req(4'd12, sa, "nr12", rb, lb, l2b);
        chk("nr0 vs nr12 res", ra, rb);
        chk_int("nr0 vs nr12 lat", la, lb);

        do_req(4'd7, rand320(), "nr7", ra, la, l2a);
        do_req(4'd15, rand320(), "nr15", ra, la, l2a);
        do_req(4'd2, rand320(), "nr2", ra, la, l2a);
        for (int i = 0; i < 6; i++)
            do_req(4'($urandom_range(0, 15)), rand320(), "rand", ra, la, l2a);

        // in_valid held high with changing inputs while busy
        sa = rand320();
        exp = ref_perm(sa, 5);
        out_ready = 1'b0; rounds = 4'd5; st_in = sa; in_valid = 1'b1;
        @(negedge clk);
        la = -1; lb = -1; ra = '0; rb = '0;
        for (int k = 1; k <= 40 && (la < 0 || lb < 0); k++) begin
            st_in  = rand320();
            rounds = 4'($urandom_range(1, 15));
            @(negedge clk);
            if (vld1 && la < 0) begin la = k; ra = so1; end
            if (vld2 && lb < 0) begin lb = k; rb = so2; end
        end
        chk_int("hold lat_u1", la, 5);
        chk_int("hold lat_u2", lb, 3);
        chk("hold res_u1", ra, exp);
        chk("hold res_u2", rb, exp);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset during RUN discards the in-flight result
        rounds = 4'd12; st_in = rand320(); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (vld1 || vld2) saw = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst idle_u1", {317'd0, rdy1, bsy1, vld1}, 320'd4);
        chk("midrst idle_u2", {317'd0, rdy2, bsy2, vld2}, 320'd4);
        chk("midrst st_u1", so1, '0);
        repeat (15) begin
            @(negedge clk);
            if (vld1 || vld2) saw = 1'b1;
        end
        chk("midrst no_valid", 320'(saw), 320'd0);
        do_req(4'd12, rand320(), "postrst", ra, la, l2a);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1, meaning ASCON rounds evaluated per clock; legal values 1 and 2.
REQ-002 SHALL have parameter SLICE_W, default 64, meaning bit-sliced S-box lane width; legal value 64 only (full-width lanes).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid_i  input  1  permutation request valid.
REQ-006 SHALL have port in_ready_o  output  1  engine can accept a request.
REQ-007 SHALL have port rounds_i  input  4  round count nr, sampled on accept.
REQ-008 SHALL have port state_i  input  320  input state {x0,x1,x2,x3,x4}, x0 in [319:256], x4 in [63:0].
REQ-009 SHALL have port out_valid_o  output  1  result valid.
REQ-010 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port state_o  output  320  permuted state, same packing as state_i.
REQ-012 SHALL have port busy_o  output  1  high in RUN and DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE); busy_o = !IDLE.
REQ-014 SHALL accept on clk edge with in_valid_i && in_ready_o: load state register from state_i, latch nr, go IDLE->RUN.
REQ-015 SHALL map rounds_i 1..12 to nr = rounds_i; rounds_i 0 or 13..15 SHALL be treated as nr = 12.
REQ-016 SHALL use round index r from 12-nr to 11; round constant c_r = ((15-r)<<4) | r (0xf0 .. 0x4b), XORed into x2[7:0].
REQ-017 SHALL per round apply: constant addition, 64 parallel 5-bit S-boxes (ASCON chi-based, x2 output inverted), then linear layer.
REQ-018 SHALL use linear layer x0^=ror19^ror28, x1^=ror61^ror39, x2^=ror1^ror6, x3^=ror10^ror17, x4^=ror7^ror41 (rotations of pre-layer value).
REQ-019 SHALL in RUN evaluate min(UNROLL, remaining) rounds per cycle; with UNROLL=2 and one round remaining, second stage SHALL be bypassed.
REQ-020 SHALL hold a round counter; RUN->DONE on the cycle the last round is written; latency accept-edge to out_valid_o high = ceil(nr/UNROLL) cycles.
REQ-021 SHALL in DONE hold state_o and out_valid_o stable until out_valid_o && out_ready_i at an edge, then go DONE->IDLE.
REQ-022 SHALL ignore in_valid_i, rounds_i, state_i while not IDLE (no overlap, no queueing).
REQ-023 SHALL drive state_o from the state register at all times; contents outside DONE are don't-care for consumers but deterministic.
REQ-024 SHALL accept a new request no earlier than the cycle after DONE->IDLE (minimum issue interval ceil(nr/UNROLL)+2 cycles with out_ready_i high).

Reset
REQ-025 SHALL on rst high at an edge: FSM to IDLE, round counter 0, state register 0, nr 12.
REQ-026 SHALL after reset present in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0.
REQ-027 SHALL let rst override all other inputs, including mid-RUN and in DONE; the in-flight result SHALL be discarded with no out_valid_o pulse.

Verification
REQ-028 SHALL cover: rst for 2 cycles -> in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0.
REQ-029 SHALL cover: UNROLL=1, state_i=0, rounds_i=1 -> out_valid_o after 1 cycle; x2=0x53FFFFFFFFFFFF90, x4=0; rest vs golden model.
REQ-030 SHALL cover: state_i=0, rounds_i=12, out_ready_i=0 for 5 cycles after DONE -> out_valid_o high at 12 cycles (UNROLL=1) / 6 (UNROLL=2), state_o stable, in_ready_o=0 throughout.
REQ-031 SHALL cover: rounds_i=0 vs rounds_i=12 with random state -> identical state_o and latency; UNROLL=2, rounds_i=7 -> latency 4, result equals UNROLL=1 result.
REQ-032 SHALL cover: in_valid_i held high with new state_i during RUN -> ignored; result matches first request only.
REQ-033 SHALL cover: rst asserted at RUN cycle 3 -> next cycle IDLE, out_valid_o never pulses, subsequent request produces golden result.
